// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and constants for the sequential CLA adder
package cla_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of nibble iterations needed to cover an operand of the given width
    function automatic int slice_count(input int width);
        return width / NIBBLE;
    endfunction

    // Operand width must be whole nibbles and hold at least one of them
    function automatic bit width_ok(input int width);
        return (width >= NIBBLE) && ((width % NIBBLE) == 0);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
module cla4_slice
    import cla_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] s,
    output logic              cout
);

    logic [NIBBLE-1:0] g;
    logic [NIBBLE-1:0] p;
    logic [NIBBLE-1:0] c;

    // Generate/propagate terms and flattened lookahead carries; no ripple path
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
    end

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle adder sharing one CLA slice; CLA_SEQ_SUB_EN adds subtract
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry_reg;
    logic [NIBBLE-1:0] a_nib;
    logic [NIBBLE-1:0] b_nib;
    logic [NIBBLE-1:0] s_nib;
    logic              c_out;
    logic              accept;
    logic              last;
    logic [WIDTH-1:0]  b_load;
    logic              c_load;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (idx == LAST_IDX);

`ifdef CLA_SEQ_SUB_EN
    // Subtraction is A + ~B + 1, so invert B at latch time and force carry-in
    assign b_load = sub ? ~B : B;
    assign c_load = sub ? 1'b1 : Cin;
`else
    assign b_load = B;
    assign c_load = Cin;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DONE can accept directly so back-to-back adds lose no cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Select the current nibble of each operand for the shared slice
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx == IDXW'(k)) begin
                a_nib = a_reg[k*NIBBLE +: NIBBLE];
                b_nib = b_reg[k*NIBBLE +: NIBBLE];
            end
        end
    end

    cla4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_reg),
        .s    (s_nib),
        .cout (c_out)
    );

    // Operand latch on accept, then per-nibble write-back and carry chaining
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            a_reg     <= A;
            b_reg     <= b_load;
            carry_reg <= c_load;
        end else if (state == RUN) begin
            for (int k = 0; k < NSLICE; k++) begin
                if (idx == IDXW'(k)) begin
                    Sum[k*NIBBLE +: NIBBLE] <= s_nib;
                end
            end
            carry_reg <= c_out;
            if (last) begin
                Cout <= c_out;
                idx  <= '0;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - self-checking bench for cla_seq_adder (optionally with CLA_SEQ_SUB_EN)
module tb_cla_seq_adder;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         sub_v;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef CLA_SEQ_SUB_EN
        .sub   (sub_v),
`endif
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain (W+1)-bit arithmetic; subtraction as A - B with no-borrow flag
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + 1;
        else   r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return r;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic s);
        A     = a;
        B     = b;
        Cin   = cin;
        sub_v = s;
        start = 1'b1;
    endtask

    // Counts negedges after the accept edge until done; cyc=-1 on timeout
    task automatic wait_done(input int c0, output int cyc, output int bcnt);
        bit seen;
        seen = 0;
        cyc  = c0;
        bcnt = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) bcnt++;
            if (done) seen = 1;
        end
        if (!seen) cyc = -1;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        int bcnt;
        issue(v.a, v.b, v.cin, v.sub);
        wait_done(0, cyc, bcnt);
        check({v.name, " latency"}, cyc, NS + 1);
        check({v.name, " busy_cycles"}, bcnt, NS);
        check({v.name, " sum"}, Sum, v.exp_sum);
        check({v.name, " cout"}, Cout, v.exp_cout);
    endtask

    initial begin
        int   cyc;
        int   bcnt;
        int   dcnt;
        vec_t v;
        logic [W:0] r;

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;
        sub_v = 1'b0;
        @(negedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", Sum, 0);
        check("reset cout", Cout, 0);
        rst = 1'b0;

        vecs.push_back('{"zero",     16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{"ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"allones",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
        vecs.push_back('{"mix_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0});
        vecs.push_back('{"mix",      16'h9E2A, 16'h26EF, 1'b0, 1'b0, 16'hC519, 1'b0});
`ifdef CLA_SEQ_SUB_EN
        vecs.push_back('{"sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{"sub_pos",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
`endif
        foreach (vecs[i]) run_vec(vecs[i]);

        // start during RUN must be ignored
        issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        wait_done(2, cyc, bcnt);
        check("ignore latency", cyc, NS + 1);
        check("ignore sum", Sum, 16'h1010);
        check("ignore cout", Cout, 0);
        @(negedge clk);
        check("ignore no_requeue busy", busy, 0);
        check("ignore no_requeue done", done, 0);

        // back-to-back: start in the DONE cycle
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_done(0, cyc, bcnt);
        check("b2b first done", done, 1);
        check("b2b first sum", Sum, 16'h0100);
        issue(16'h8000, 16'h8000, 1'b1, 1'b0);
        wait_done(0, cyc, bcnt);
        check("b2b second latency", cyc, NS + 1);
        check("b2b second busy_cycles", bcnt, NS);
        check("b2b second sum", Sum, 16'h0001);
        check("b2b second cout", Cout, 1);

        // reset during the second RUN cycle aborts with no done
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", busy, 0);
        check("midreset sum", Sum, 0);
        check("midreset cout", Cout, 0);
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midreset no_done", dcnt, 0);
        v = '{"after_reset", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0};
        run_vec(v);

        // randomized against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            v.name = $sformatf("rand%0d", i);
            v.a    = W'($urandom);
            v.b    = W'($urandom);
            v.cin  = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
            v.sub  = 1'($urandom);
`else
            v.sub  = 1'b0;
`endif
            r          = model(v.a, v.b, v.cin, v.sub);
            v.exp_sum  = r[W-1:0];
            v.exp_cout = r[W];
            run_vec(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
